// File: rtl/multicycle_control.sv
// Multi-cycle RV32 main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory timeout trap.
// Define CTRL_ITYPE_EN to decode opcode 0010011 as an I-type ALU instruction (else it traps).
module multicycle_control #(
  parameter int unsigned OPCODE_W    = 7,
  parameter int unsigned ALU_OP_W    = 2,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [OPCODE_W-1:0] op_code,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_R      = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);
`ifdef CTRL_ITYPE_EN
  localparam logic [OPCODE_W-1:0] OP_I      = OPCODE_W'(7'b0010011);
`endif

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StMemAddr, StMemRd, StMemWb, StMemWr,
    StExecR, StExecI, StAluWb, StBranch, StTrap
  } state_t;

  // fetch and done_rdy are qualified by mem_ready at the output.
  typedef struct packed {
    logic                fetch;
    logic                done_rdy;
    logic                alu_src;
    logic                mem_to_reg;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic [ALU_OP_W-1:0] alu_op;
    logic                done;
    logic                trap;
  } ctrl_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             store_q, store_d;
  ctrl_t            ctrl_q;
  logic             wait_st;

  function automatic ctrl_t decode_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch:   begin c.fetch = 1'b1; c.mem_read = 1'b1; end
      StMemAddr: c.alu_src = 1'b1;
      StMemRd:   c.mem_read = 1'b1;
      StMemWb:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.done = 1'b1; end
      StMemWr:   begin c.mem_write = 1'b1; c.done_rdy = 1'b1; end
      StExecR:   c.alu_op = ALU_OP_W'(2'b10);
      StExecI:   begin c.alu_src = 1'b1; c.alu_op = ALU_OP_W'(2'b11); end
      StAluWb:   begin c.reg_write = 1'b1; c.done = 1'b1; end
      StBranch:  begin c.branch = 1'b1; c.alu_op = ALU_OP_W'(2'b01); c.done = 1'b1; end
      StTrap:    c.trap = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  assign wait_st = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    store_d = store_q;
    unique case (state_q)
      StIdle:    if (en) state_d = StFetch;
      StFetch:   if (mem_ready) state_d = StDecode;
      StDecode: begin
        store_d = (op_code == OP_STORE);
        if (op_code == OP_LOAD || op_code == OP_STORE) state_d = StMemAddr;
        else if (op_code == OP_R)                      state_d = StExecR;
        else if (op_code == OP_BRANCH)                 state_d = StBranch;
`ifdef CTRL_ITYPE_EN
        else if (op_code == OP_I)                      state_d = StExecI;
`endif
        else begin
          state_d = StTrap;
          cause_d = 2'b01;
        end
      end
      StMemAddr: state_d = store_q ? StMemWr : StMemRd;
      StMemRd:   if (mem_ready) state_d = StMemWb;
      StMemWr:   if (mem_ready) state_d = en ? StFetch : StIdle;
      StExecR,
      StExecI:   state_d = StAluWb;
      StMemWb,
      StAluWb,
      StBranch:  state_d = en ? StFetch : StIdle;
      StTrap:    state_d = StTrap;
      default:   state_d = StIdle;
    endcase
    // Trap on the cycle that completes MEM_TIMEOUT consecutive not-ready cycles.
    if (wait_st && !mem_ready) begin
      if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
        state_d = StTrap;
        cause_d = 2'b10;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cause_q <= 2'b00;
      store_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      store_q <= store_d;
      ctrl_q  <= decode_ctrl(state_d);
    end
  end

  assign pc_write   = ctrl_q.fetch & mem_ready;
  assign ir_write   = ctrl_q.fetch & mem_ready;
  assign alu_src    = ctrl_q.alu_src;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign branch     = ctrl_q.branch;
  assign alu_op     = ctrl_q.alu_op;
  assign instr_done = ctrl_q.done | (ctrl_q.done_rdy & mem_ready);
  assign trap       = ctrl_q.trap;
  assign trap_cause = cause_q;

endmodule
